// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the toggle req/ack CDC send controller.
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ERROR = 2'd2
   } state_t;

   // The timeout counter only has to reach TIMEOUT_CYCLES-1.
   function automatic int tmo_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/ack_sync_chain.sv
// Single-bit synchroniser chain for the ack toggle coming back from the receive domain.
module ack_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic in_clk,
   input  logic in_rst_n,
   input  logic in_d,
   output logic out_q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) sync_q <= '0;
      else           sync_q <= {sync_q[STAGES-2:0], in_d};
   end

   assign out_q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_sender.sv
// Send side of a toggle req/ack multi-bit CDC transfer: holds the word on the bus,
// flips req, and frees the channel once the synchronised ack matches req.
module cdc_handshake_sender
   import cdc_hs_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int DELAY_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data_bus,
   output logic                  out_req,
   input  logic                  in_ack,
   input  logic                  in_clear,
   output logic                  out_done,
   output logic                  out_timeout,
   output logic                  out_err,
   output logic [CNT_WIDTH-1:0]  out_count
);

   localparam int             TW       = tmo_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                state, state_nxt;
   logic                  ack_s;
   logic [TW-1:0]         tmo_cnt, tmo_nxt;
   logic                  req_nxt, ready_nxt, done_nxt, timeout_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic [CNT_WIDTH-1:0]  count_nxt;

   ack_sync_chain #(.STAGES(DELAY_CYCLES)) u_ack_sync (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .in_d     (in_ack),
      .out_q    (ack_s)
   );

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state        <= IDLE;
         tmo_cnt      <= '0;
         out_req      <= 1'b0;
         out_data_bus <= '0;
         out_ready    <= 1'b0;
         out_done     <= 1'b0;
         out_timeout  <= 1'b0;
         out_count    <= '0;
      end else begin
         state        <= state_nxt;
         tmo_cnt      <= tmo_nxt;
         out_req      <= req_nxt;
         out_data_bus <= data_nxt;
         out_ready    <= ready_nxt;
         out_done     <= done_nxt;
         out_timeout  <= timeout_nxt;
         out_count    <= count_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmo_nxt     = tmo_cnt;
      req_nxt     = out_req;
      data_nxt    = out_data_bus;
      ready_nxt   = out_ready;
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
      count_nxt   = out_count;
      unique case (state)
         IDLE: begin
            ready_nxt = 1'b1;
            if (in_valid && out_ready) begin
               data_nxt  = in_data;
               req_nxt   = ~out_req;
               ready_nxt = 1'b0;
               tmo_nxt   = '0;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            tmo_nxt = tmo_cnt + 1'b1;
            // A matching ack takes priority over a timeout landing on the same cycle.
            if (ack_s == out_req) begin
               state_nxt = IDLE;
               ready_nxt = 1'b1;
               done_nxt  = 1'b1;
               count_nxt = out_count + 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
               state_nxt   = ERROR;
               timeout_nxt = 1'b1;
            end
         end
         ERROR: begin
            // Leave only once the late ack has landed, so req/ack parity is back in step.
            if (in_clear && ack_s == out_req) begin
               state_nxt = IDLE;
               ready_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_err = (state == ERROR);

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Self-checking bench for cdc_handshake_sender: a vector table for one transfer,
// directed corner sequences, and randomized transfers against a latency model.
module tb_cdc_handshake_sender;

   localparam int DW = 8;
   localparam int D  = 2;
   localparam int T  = 16;
   localparam int CW = 4;

   logic          in_clk = 1'b0, in_rst_n = 1'b0, in_valid = 1'b0, in_ack = 1'b0, in_clear = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready, out_req, out_done, out_timeout, out_err;
   logic [DW-1:0] out_data_bus;
   logic [CW-1:0] out_count;

   int            n_chk = 0, n_err = 0;
   logic          m_req = 1'b0;
   logic [DW-1:0] m_bus = '0;
   int            m_count = 0;

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic          ack;
      logic          rdy;
      logic          req;
      logic [DW-1:0] bus;
      logic          done;
      logic [CW-1:0] cnt;
   } vec_t;
   vec_t tbl[8];

   always #5 in_clk = ~in_clk;

   cdc_handshake_sender #(
      .DATA_WIDTH(DW), .DELAY_CYCLES(D), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)
   ) dut (
      .in_clk       (in_clk),
      .in_rst_n     (in_rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .out_ready    (out_ready),
      .out_data_bus (out_data_bus),
      .out_req      (out_req),
      .in_ack       (in_ack),
      .in_clear     (in_clear),
      .out_done     (out_done),
      .out_timeout  (out_timeout),
      .out_err      (out_err),
      .out_count    (out_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic rdy, input logic dn,
                            input logic to, input logic er);
      check({tag, " ready"},   32'(out_ready),    32'(rdy));
      check({tag, " req"},     32'(out_req),      32'(m_req));
      check({tag, " bus"},     32'(out_data_bus), 32'(m_bus));
      check({tag, " done"},    32'(out_done),     32'(dn));
      check({tag, " timeout"}, 32'(out_timeout),  32'(to));
      check({tag, " err"},     32'(out_err),      32'(er));
      check({tag, " count"},   32'(out_count),    32'(m_count));
   endtask

   // One transaction. Ack is toggled just after accept edge + k; the model predicts
   // completion at edge k+D+1 if that is within T, otherwise a timeout at edge T.
   task automatic do_xfer(input logic [DW-1:0] d, input int k, input string tag);
      bit ok;
      int ev;
      ok = (k + D + 1 <= T);
      ev = ok ? k + D + 1 : T;
      in_valid = 1'b1;
      in_data  = d;
      tick();
      m_req = ~m_req;
      m_bus = d;
      check_all({tag, " accept"}, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int e = 1; e <= ev; e++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = DW'($urandom);
         if (e == k + 1) in_ack = ~in_ack;
         tick();
         if (e < ev) check_all({tag, " wait"}, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      if (ok) begin
         m_count = (m_count + 1) % (1 << CW);
         check_all({tag, " done"}, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
         check_all({tag, " idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
         check_all({tag, " timeout"}, 1'b0, 1'b0, 1'b1, 1'b1);
         tick();
         check_all({tag, " err hold"}, 1'b0, 1'b0, 1'b0, 1'b1);
         if (k >= T) begin
            in_clear = 1'b1;
            tick();
            in_clear = 1'b0;
            check_all({tag, " clr ignored"}, 1'b0, 1'b0, 1'b0, 1'b1);
            in_ack = ~in_ack;
         end
         repeat (D) tick();
         check_all({tag, " late ack"}, 1'b0, 1'b0, 1'b0, 1'b1);
         in_clear = 1'b1;
         tick();
         in_clear = 1'b0;
         check_all({tag, " recovered"}, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
      tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 4'd1};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd1};

      // Reset then idle
      repeat (5) begin
         tick();
         check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      in_rst_n = 1'b1;
      check_all("release", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_all("first edge", 1'b1, 1'b0, 1'b0, 1'b0);

      // Single transfer from the vector table
      for (int i = 0; i < 8; i++) begin
         in_valid = tbl[i].valid;
         in_data  = tbl[i].data;
         in_ack   = tbl[i].ack;
         tick();
         check($sformatf("vec%0d ready", i), 32'(out_ready),    32'(tbl[i].rdy));
         check($sformatf("vec%0d req", i),   32'(out_req),      32'(tbl[i].req));
         check($sformatf("vec%0d bus", i),   32'(out_data_bus), 32'(tbl[i].bus));
         check($sformatf("vec%0d done", i),  32'(out_done),     32'(tbl[i].done));
         check($sformatf("vec%0d count", i), 32'(out_count),    32'(tbl[i].cnt));
         check($sformatf("vec%0d err", i),   32'({out_timeout, out_err}), 32'd0);
      end
      in_valid = 1'b0;
      m_req    = 1'b1;
      m_bus    = 8'hA5;
      m_count  = 1;

      // Back-to-back words
      do_xfer(8'h01, 1, "b2b1");
      do_xfer(8'h02, 3, "b2b2");
      do_xfer(8'h03, 0, "b2b3");

      // Timeout with clear-before-ack, then race boundaries either side of the timeout
      do_xfer(8'h3C, 20, "timeout");
      do_xfer(8'h5A, T - D - 1, "ack wins");
      do_xfer(8'h6B, T - D, "ack late");

      // Spurious ack and stray clear in IDLE
      in_ack = ~in_ack;
      in_clear = 1'b1;
      tick();
      in_clear = 1'b0;
      repeat (D + 1) tick();
      check_all("spurious", 1'b1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hC3;
      tick();
      in_valid = 1'b0;
      m_req = ~m_req;
      m_bus = 8'hC3;
      check_all("spur accept", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      m_count = (m_count + 1) % (1 << CW);
      check_all("spur done", 1'b1, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of WAIT
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      in_rst_n = 1'b0;
      in_ack   = 1'b0;
      #1;
      m_req = 1'b0;
      m_bus = '0;
      m_count = 0;
      check_all("mid reset", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      in_rst_n = 1'b1;
      tick();
      check_all("after reset", 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomized transfers; count wraps modulo 2^CW along the way
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         do_xfer(DW'($urandom), int'($urandom_range(0, 20)), $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
